// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and hands {pc, inst} to decode.
// Optional retired-fetch counter enabled by defining FETCH_PERF_CNT_EN.
module fetch #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int unsigned ROM_LAT    = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        IF_valid,
    input  logic        next_fetch,
    input  logic [31:0] inst,
    input  logic [32:0] jbr_bus,
    input  logic [32:0] exc_bus,
    input  logic        cancel,
    output logic [31:0] inst_addr,
    output logic        IF_over,
    output logic [63:0] IF_ID_bus,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] LatMax = 2'(ROM_LAT);

    logic [31:0] pc_q, pc_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic        redirect_pending_q, redirect_pending_d;
    logic [31:0] redirect_target_q, redirect_target_d;

    logic        jbr_taken;
    logic [31:0] jbr_target;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        lat_done;
    logic        accept;
    logic        pc_load;
    logic [31:0] next_pc;

    always_comb begin
        jbr_taken  = jbr_bus[32];
        jbr_target = jbr_bus[31:0];
        exc_valid  = exc_bus[32];
        exc_pc     = exc_bus[31:0];

        lat_done = (lat_cnt_q == LatMax);
        IF_over  = IF_valid & lat_done & ~cancel;
        accept   = next_fetch & IF_over;
        // An exception redirects even when decode is stalled or the slot is empty.
        pc_load  = accept | exc_valid;

        if (exc_valid) begin
            next_pc = exc_pc;
        end else if (redirect_pending_q) begin
            next_pc = redirect_target_q;
        end else if (jbr_taken) begin
            next_pc = jbr_target;
        end else begin
            next_pc = pc_q + 32'd4;
        end

        pc_d = pc_load ? next_pc : pc_q;

        lat_cnt_d = lat_cnt_q;
        if (pc_load || cancel) begin
            lat_cnt_d = 2'd0;
        end else if (!lat_done) begin
            lat_cnt_d = lat_cnt_q + 2'd1;
        end

        // A branch seen while the PC cannot move is held until the next load.
        redirect_pending_d = redirect_pending_q;
        redirect_target_d  = redirect_target_q;
        if (pc_load) begin
            redirect_pending_d = 1'b0;
        end else if (jbr_taken) begin
            redirect_pending_d = 1'b1;
            redirect_target_d  = jbr_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q               <= START_ADDR;
            lat_cnt_q          <= 2'd0;
            redirect_pending_q <= 1'b0;
            redirect_target_q  <= 32'd0;
        end else begin
            pc_q               <= pc_d;
            lat_cnt_q          <= lat_cnt_d;
            redirect_pending_q <= redirect_pending_d;
            redirect_target_q  <= redirect_target_d;
        end
    end

    assign inst_addr = pc_q;
    assign IF_ID_bus = {pc_q, inst};
    assign IF_pc     = pc_q;
    assign IF_inst   = inst;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + {31'd0, accept};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: one instance at ROM latency 1, one at ROM latency 3,
// each fed by a behavioural ROM whose data trails the address by the configured latency.
module tb_fetch;

    localparam logic [31:0] Start = 32'h0000_0000;
`ifdef FETCH_PERF_CNT_EN
    localparam logic [31:0] ExpCnt = 32'd5;
`else
    localparam logic [31:0] ExpCnt = 32'd0;
`endif

    logic        clk;
    logic        resetn;
    logic        if_valid;
    logic        next_fetch;
    logic [32:0] jbr_bus;
    logic [32:0] exc_bus;
    logic        cancel;

    logic [31:0] inst1, addr1, pc1, iinst1, cnt1;
    logic        over1;
    logic [63:0] bus1;
    logic [31:0] inst3, addr3, pc3, iinst3, cnt3;
    logic        over3;
    logic [63:0] bus3;

    logic [31:0] a1_q;
    logic [31:0] a3_q [3];

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q [$];

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    fetch #(.START_ADDR(Start), .ROM_LAT(1)) u_fetch1 (
        .clk(clk), .resetn(resetn), .IF_valid(if_valid), .next_fetch(next_fetch),
        .inst(inst1), .jbr_bus(jbr_bus), .exc_bus(exc_bus), .cancel(cancel),
        .inst_addr(addr1), .IF_over(over1), .IF_ID_bus(bus1), .IF_pc(pc1),
        .IF_inst(iinst1), .fetch_count(cnt1)
    );

    fetch #(.START_ADDR(Start), .ROM_LAT(3)) u_fetch3 (
        .clk(clk), .resetn(resetn), .IF_valid(if_valid), .next_fetch(next_fetch),
        .inst(inst3), .jbr_bus(jbr_bus), .exc_bus(exc_bus), .cancel(cancel),
        .inst_addr(addr3), .IF_over(over3), .IF_ID_bus(bus3), .IF_pc(pc3),
        .IF_inst(iinst3), .fetch_count(cnt3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        a1_q    <= addr1;
        a3_q[0] <= addr3;
        a3_q[1] <= a3_q[0];
        a3_q[2] <= a3_q[1];
    end
    assign inst1 = rom(a1_q);
    assign inst3 = rom(a3_q[2]);

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; if_valid = 1'b0; next_fetch = 1'b0;
        jbr_bus = '0; exc_bus = '0; cancel = 1'b0;
        cyc();
        cyc();
        checks++; if (addr1 !== Start) begin failures++;
            $display("FAIL reset_addr1 got=%h exp=%h", addr1, Start); end
        checks++; if (over1 !== 1'b0) begin failures++;
            $display("FAIL reset_over1 got=%b exp=0", over1); end
        checks++; if (cnt1 !== 32'd0) begin failures++;
            $display("FAIL reset_cnt1 got=%h exp=0", cnt1); end
        checks++; if (addr3 !== Start) begin failures++;
            $display("FAIL reset_addr3 got=%h exp=%h", addr3, Start); end
        checks++; if (over3 !== 1'b0) begin failures++;
            $display("FAIL reset_over3 got=%b exp=0", over3); end
        resetn = 1'b1;
    endtask

    task automatic test_sequential();
        logic [63:0] e;
        if_valid = 1'b1; next_fetch = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({32'(i * 4), rom(32'(i * 4))});
        #1;
        for (int k = 0; k < 6; k++) begin
            checks++; if (addr1 !== 32'(4 * (k / 2))) begin failures++;
                $display("FAIL seq_addr k=%0d got=%h exp=%h", k, addr1, 4 * (k / 2)); end
            checks++; if (over1 !== 1'(k % 2)) begin failures++;
                $display("FAIL seq_over k=%0d got=%b exp=%0d", k, over1, k % 2); end
            if (over1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if (bus1 !== e) begin failures++;
                    $display("FAIL seq_bus got=%h exp=%h", bus1, e); end
            end
            cyc();
        end
        checks++; if (exp_q.size() != 0) begin failures++;
            $display("FAIL seq_drain got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_branch_hold();
        for (int i = 0; i < 10 && addr1 != 32'h10; i++) begin
            next_fetch = 1'b1;
            cyc();
        end
        checks++; if (addr1 !== 32'h10) begin failures++;
            $display("FAIL br_reach got=%h exp=00000010", addr1); end
        next_fetch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            jbr_bus = (i == 0) ? {1'b1, 32'h40} : '0;
            cyc();
            checks++; if (addr1 !== 32'h10) begin failures++;
                $display("FAIL br_hold i=%0d got=%h exp=00000010", i, addr1); end
        end
        jbr_bus = '0;
        next_fetch = 1'b1;
        #1;
        checks++; if (over1 !== 1'b1) begin failures++;
            $display("FAIL br_ready got=%b exp=1", over1); end
        cyc();
        checks++; if (addr1 !== 32'h40) begin failures++;
            $display("FAIL br_target got=%h exp=00000040", addr1); end
        checks++; if (over1 !== 1'b0) begin failures++;
            $display("FAIL br_over0 got=%b exp=0", over1); end
        next_fetch = 1'b0;
        cyc();
        checks++; if (bus1 !== {32'h40, rom(32'h40)}) begin failures++;
            $display("FAIL br_bus got=%h exp=%h", bus1, {32'h40, rom(32'h40)}); end
    endtask

    task automatic test_exception();
        logic [63:0] e;
        jbr_bus = {1'b1, 32'h24}; next_fetch = 1'b1;
        cyc();
        jbr_bus = '0; next_fetch = 1'b0;
        checks++; if (addr1 !== 32'h24) begin failures++;
            $display("FAIL exc_setup got=%h exp=00000024", addr1); end
        exc_bus = {1'b1, 32'h0}; jbr_bus = {1'b1, 32'h80};
        cyc();
        exc_bus = '0; jbr_bus = '0;
        checks++; if (addr1 !== 32'h0) begin failures++;
            $display("FAIL exc_pc got=%h exp=00000000", addr1); end
        exp_q.push_back({32'h0, rom(32'h0)});
        exp_q.push_back({32'h4, rom(32'h4)});
        next_fetch = 1'b1;
        #1;
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            checks++; if (addr1 === 32'h80) begin failures++;
                $display("FAIL exc_branch_dropped got=%h exp=not 00000080", addr1); end
            if (over1) begin
                e = exp_q.pop_front();
                checks++; if (bus1 !== e) begin failures++;
                    $display("FAIL exc_bus got=%h exp=%h", bus1, e); end
            end
            cyc();
        end
        checks++; if (exp_q.size() != 0) begin failures++;
            $display("FAIL exc_timeout got=%0d exp=0", exp_q.size()); exp_q.delete(); end
        next_fetch = 1'b0;
    endtask

    task automatic test_cancel();
        logic [31:0] p;
        cyc();
        p = addr1;
        checks++; if (over1 !== 1'b1) begin failures++;
            $display("FAIL cancel_pre got=%b exp=1", over1); end
        cancel = 1'b1; next_fetch = 1'b1;
        #1;
        checks++; if (over1 !== 1'b0) begin failures++;
            $display("FAIL cancel_over got=%b exp=0", over1); end
        cyc();
        cancel = 1'b0; next_fetch = 1'b0;
        #1;
        checks++; if (addr1 !== p) begin failures++;
            $display("FAIL cancel_pc got=%h exp=%h", addr1, p); end
        checks++; if (over1 !== 1'b0) begin failures++;
            $display("FAIL cancel_lat got=%b exp=0", over1); end
        cyc();
        checks++; if (over1 !== 1'b1) begin failures++;
            $display("FAIL cancel_refetch got=%b exp=1", over1); end
        checks++; if (bus1 !== {p, rom(p)}) begin failures++;
            $display("FAIL cancel_bus got=%h exp=%h", bus1, {p, rom(p)}); end
    endtask

    task automatic test_if_valid_low();
        logic [31:0] p;
        next_fetch = 1'b1;
        p = addr1 + 32'd4;
        cyc();
        if_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (over1 !== 1'b0) begin failures++;
                $display("FAIL ivl_over i=%0d got=%b exp=0", i, over1); end
            cyc();
            checks++; if (addr1 !== p) begin failures++;
                $display("FAIL ivl_pc i=%0d got=%h exp=%h", i, addr1, p); end
        end
        if_valid = 1'b1;
        #1;
        checks++; if (over1 !== 1'b1) begin failures++;
            $display("FAIL ivl_ready got=%b exp=1", over1); end
        next_fetch = 1'b0;
    endtask

    task automatic test_wrap();
        exc_bus = {1'b1, 32'hFFFF_FFFC};
        cyc();
        exc_bus = '0;
        checks++; if (addr1 !== 32'hFFFF_FFFC) begin failures++;
            $display("FAIL wrap_exc got=%h exp=fffffffc", addr1); end
        next_fetch = 1'b1;
        cyc();
        checks++; if (bus1 !== {32'hFFFF_FFFC, rom(32'hFFFF_FFFC)}) begin failures++;
            $display("FAIL wrap_bus got=%h exp=%h", bus1, {32'hFFFF_FFFC, rom(32'hFFFF_FFFC)}); end
        cyc();
        checks++; if (addr1 !== 32'h0) begin failures++;
            $display("FAIL wrap_pc got=%h exp=00000000", addr1); end
        next_fetch = 1'b0;
    endtask

    task automatic test_lat3();
        logic [63:0] e;
        do_reset();
        if_valid = 1'b1; next_fetch = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({32'(i * 4), rom(32'(i * 4))});
        #1;
        for (int k = 0; k < 12; k++) begin
            checks++; if (addr3 !== 32'(4 * (k / 4))) begin failures++;
                $display("FAIL lat3_addr k=%0d got=%h exp=%h", k, addr3, 4 * (k / 4)); end
            checks++; if (over3 !== (k % 4 == 3)) begin failures++;
                $display("FAIL lat3_over k=%0d got=%b exp=%b", k, over3, (k % 4 == 3)); end
            if (over3 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if (bus3 !== e) begin failures++;
                    $display("FAIL lat3_bus got=%h exp=%h", bus3, e); end
            end
            cyc();
        end
        checks++; if (exp_q.size() != 0) begin failures++;
            $display("FAIL lat3_drain got=%0d exp=0", exp_q.size()); exp_q.delete(); end
        next_fetch = 1'b0;
    endtask

    task automatic test_perf();
        do_reset();
        if_valid = 1'b1; next_fetch = 1'b1;
        repeat (10) cyc();
        next_fetch = 1'b0;
        cyc();
        cancel = 1'b1; next_fetch = 1'b1;
        cyc();
        cancel = 1'b0; next_fetch = 1'b0;
        exc_bus = {1'b1, 32'h100};
        cyc();
        exc_bus = '0;
        checks++; if (cnt1 !== ExpCnt) begin failures++;
            $display("FAIL perf_count got=%0d exp=%0d", cnt1, ExpCnt); end
        resetn = 1'b0;
        cyc();
        checks++; if (cnt1 !== 32'd0) begin failures++;
            $display("FAIL perf_reset_cnt got=%0d exp=0", cnt1); end
        checks++; if (addr1 !== Start) begin failures++;
            $display("FAIL perf_reset_pc got=%h exp=%h", addr1, Start); end
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch_hold();
        test_exception();
        test_cancel();
        test_if_valid_low();
        test_wrap();
        test_lat3();
        test_perf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
